// File: rtl/calculadora_multidigito.sv
// ----------------------------------------------------------------------------
// calculadora_multidigito
// Multi-digit keypad calculator. Builds decimal operands A and B from keypad
// codes, computes A+B, |A-B| (with sign) or A*B (multiply by repeated
// addition), then streams the result to the 7-segment driver as
// (position, digit) pairs, one pair per cycle, least-significant digit first.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   cmd        : keypad code 0-9 digit, A add, B sub, C mult, D clear,
//                E equals, F backspace
//   cmd_valid  : one-cycle strobe qualifying cmd
//   status     : 00 ERRO, 01 PRONTA, 10 OCUPADA, 11 IMPRIME (registered)
//   pos        : display position of dig (0 = LSD), valid while IMPRIME
//   dig        : BCD digit, 4'hB = minus sign, valid while IMPRIME
// ----------------------------------------------------------------------------
module calculadora_multidigito #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 16,
   parameter int POSW   = $clog2(DIGITS + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [3:0]      cmd,
   input  logic            cmd_valid,
   output logic [1:0]      status,
   output logic [POSW-1:0] pos,
   output logic [3:0]      dig
);

   typedef enum logic [2:0] {
      S_ENTRY_A, S_ENTRY_B, S_EXEC, S_SHOW, S_RESULT, S_ERR
   } state_t;

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_PASS} op_t;

   localparam logic [1:0] ST_ERRO    = 2'b00;
   localparam logic [1:0] ST_PRONTA  = 2'b01;
   localparam logic [1:0] ST_OCUPADA = 2'b10;
   localparam logic [1:0] ST_IMPRIME = 2'b11;

   localparam logic [3:0] K_ADD = 4'hA;
   localparam logic [3:0] K_SUB = 4'hB;
   localparam logic [3:0] K_MUL = 4'hC;
   localparam logic [3:0] K_CLR = 4'hD;
   localparam logic [3:0] K_EQ  = 4'hE;
   localparam logic [3:0] K_BSP = 4'hF;

   localparam logic [WIDTH-1:0] TEN     = WIDTH'(10);
   localparam logic [WIDTH-1:0] MAXV    = WIDTH'(10**DIGITS - 1);
   localparam logic [POSW-1:0]  CNT_MAX = POSW'(DIGITS);
   localparam logic [POSW-1:0]  POS_TOP = POSW'(DIGITS - 1);

   function automatic logic [WIDTH-1:0] div10(input logic [WIDTH-1:0] v);
      return v / TEN;
   endfunction

   function automatic logic [3:0] mod10(input logic [WIDTH-1:0] v);
      return 4'(v % TEN);
   endfunction

   state_t           state_q;
   op_t              op_q;
   logic [1:0]       status_q;
   logic [POSW-1:0]  pos_q;
   logic [3:0]       dig_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, sh_q;
   logic [POSW-1:0]  cnt_q;
   logic             neg_q;

   logic             is_dig, is_op, clr_d;
   op_t              key_op;
   logic [WIDTH-1:0] opnd, push_d, bsp_d, sum_d, mac_d, res_d;

   assign is_dig = (cmd <= 4'd9);
   assign is_op  = (cmd == K_ADD) || (cmd == K_SUB) || (cmd == K_MUL);
   assign key_op = (cmd == K_ADD) ? OP_ADD : (cmd == K_SUB) ? OP_SUB : OP_MUL;

   // Clear behaves exactly like reset, but only from the states that accept it.
   assign clr_d = cmd_valid && (cmd == K_CLR) &&
                  ((state_q == S_ENTRY_A) || (state_q == S_ENTRY_B) || (state_q == S_RESULT));

   // Digit entry and backspace share one datapath on whichever operand is open.
   assign opnd   = (state_q == S_ENTRY_B) ? b_q : a_q;
   assign push_d = opnd * TEN + WIDTH'(cmd);
   assign bsp_d  = div10(opnd);

   assign sum_d = a_q + b_q;
   assign mac_d = acc_q + a_q;

   always_comb begin
      res_d = a_q;
      case (op_q)
         OP_ADD:  res_d = sum_d;
         OP_SUB:  res_d = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
         OP_MUL:  res_d = acc_q;
         default: res_d = a_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || clr_d) begin
         state_q  <= S_ENTRY_A;
         status_q <= ST_PRONTA;
         pos_q    <= '0;
         dig_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         sh_q     <= '0;
         op_q     <= OP_ADD;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         case (state_q)
            S_ENTRY_A: if (cmd_valid) begin
               if (is_dig) begin
                  if (cnt_q < CNT_MAX) begin
                     a_q   <= push_d;
                     cnt_q <= cnt_q + POSW'(1);
                  end
               end else if (cmd == K_BSP) begin
                  a_q <= bsp_d;
                  if (cnt_q != '0) cnt_q <= cnt_q - POSW'(1);
               end else if (is_op) begin
                  op_q    <= key_op;
                  b_q     <= '0;
                  cnt_q   <= '0;
                  state_q <= S_ENTRY_B;
               end else if (cmd == K_EQ) begin
                  op_q     <= OP_PASS;
                  acc_q    <= '0;
                  state_q  <= S_EXEC;
                  status_q <= ST_OCUPADA;
               end
            end
            S_ENTRY_B: if (cmd_valid) begin
               if (is_dig) begin
                  if (cnt_q < CNT_MAX) begin
                     b_q   <= push_d;
                     cnt_q <= cnt_q + POSW'(1);
                  end
               end else if (cmd == K_BSP) begin
                  b_q <= bsp_d;
                  if (cnt_q != '0) cnt_q <= cnt_q - POSW'(1);
               end else if (is_op) begin
                  // An operator after a B digit is a malformed expression.
                  if (cnt_q == '0) begin
                     op_q <= key_op;
                  end else begin
                     state_q  <= S_ERR;
                     status_q <= ST_ERRO;
                  end
               end else if (cmd == K_EQ) begin
                  acc_q    <= '0;
                  state_q  <= S_EXEC;
                  status_q <= ST_OCUPADA;
               end
            end
            S_EXEC: begin
               // Multiply uses b_q as its down-counter; B is not needed afterwards.
               if ((op_q == OP_MUL) && (b_q != '0)) begin
                  if (mac_d > MAXV) begin
                     state_q  <= S_ERR;
                     status_q <= ST_ERRO;
                  end else begin
                     acc_q <= mac_d;
                     b_q   <= b_q - WIDTH'(1);
                  end
               end else if ((op_q == OP_ADD) && (sum_d > MAXV)) begin
                  state_q  <= S_ERR;
                  status_q <= ST_ERRO;
               end else begin
                  acc_q    <= res_d;
                  neg_q    <= (op_q == OP_SUB) && (a_q < b_q);
                  sh_q     <= div10(res_d);
                  dig_q    <= mod10(res_d);
                  pos_q    <= '0;
                  state_q  <= S_SHOW;
                  status_q <= ST_IMPRIME;
               end
            end
            S_SHOW: begin
               // sh_q holds the result shifted right by (pos_q + 1) decimal digits.
               if (pos_q < POS_TOP) begin
                  pos_q <= pos_q + POSW'(1);
                  dig_q <= mod10(sh_q);
                  sh_q  <= div10(sh_q);
               end else if (neg_q && (pos_q == POS_TOP)) begin
                  pos_q <= CNT_MAX;
                  dig_q <= 4'hB;
               end else begin
                  pos_q    <= '0;
                  dig_q    <= '0;
                  state_q  <= S_RESULT;
                  status_q <= ST_PRONTA;
               end
            end
            S_RESULT: if (cmd_valid) begin
               if (is_dig) begin
                  a_q     <= WIDTH'(cmd);
                  cnt_q   <= POSW'(1);
                  state_q <= S_ENTRY_A;
               end else if (is_op) begin
                  if (neg_q) begin
                     state_q  <= S_ERR;
                     status_q <= ST_ERRO;
                  end else begin
                     a_q     <= acc_q;
                     op_q    <= key_op;
                     b_q     <= '0;
                     cnt_q   <= '0;
                     state_q <= S_ENTRY_B;
                  end
               end else if (cmd == K_EQ) begin
                  sh_q     <= div10(acc_q);
                  dig_q    <= mod10(acc_q);
                  pos_q    <= '0;
                  state_q  <= S_SHOW;
                  status_q <= ST_IMPRIME;
               end
            end
            S_ERR: begin
               status_q <= ST_ERRO;
            end
            default: begin
               state_q  <= S_ERR;
               status_q <= ST_ERRO;
            end
         endcase
      end
   end

   assign status = status_q;
   assign pos    = pos_q;
   assign dig    = dig_q;

endmodule

// File: tb/tb_calculadora_multidigito.sv
// ----------------------------------------------------------------------------
// Testbench for calculadora_multidigito. A behavioural model tracks operands,
// operator and mode from key presses; expected results, busy latencies and
// digit streams are computed with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_calculadora_multidigito;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 16;
   localparam int POSW   = $clog2(DIGITS + 1);
   localparam int MAXV   = 10**DIGITS - 1;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [3:0]      cmd = 4'd0;
   logic            cmd_valid = 1'b0;
   logic [1:0]      status;
   logic [POSW-1:0] pos;
   logic [3:0]      dig;

   int errors = 0;
   int checks = 0;

   // model: mode 0 entry A, 1 entry B, 2 result, 3 error; op 10/11/12 key, 13 pass
   int  mA, mB, mAcc, mCnt, mOp, mNeg, mMode;
   bit  poke_en = 1'b0;

   calculadora_multidigito #(.DIGITS(DIGITS), .WIDTH(WIDTH), .POSW(POSW)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .status    (status),
      .pos       (pos),
      .dig       (dig)
   );

   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mA = 0; mB = 0; mAcc = 0; mCnt = 0; mOp = 10; mNeg = 0; mMode = 0;
   endtask

   task automatic drive(input int k);
      cmd = 4'(k);
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      model_clear();
      chk("reset_status", 32'(status), 1);
      chk("reset_pos", 32'(pos), 0);
      chk("reset_dig", 32'(dig), 0);
   endtask

   task automatic run_show(input int r, input int ng);
      for (int p = 0; p < DIGITS + ng; p++) begin
         chk("show_status", 32'(status), 3);
         chk("show_pos", 32'(pos), p);
         chk("show_dig", 32'(dig), (p == DIGITS) ? 11 : (r / (10**p)) % 10);
         if (poke_en && p == 1) begin
            cmd = 4'($urandom_range(0, 15));
            cmd_valid = 1'b1;
            @(posedge clock); #1;
            cmd_valid = 1'b0;
         end else begin
            @(posedge clock); #1;
         end
      end
      chk("after_show_status", 32'(status), 1);
   endtask

   task automatic do_equals();
      int r, lat, j, busy, ng;
      bit ovf;
      ng = 0; ovf = 1'b0; j = 0; lat = 1;
      case (mOp)
         10: begin r = mA + mB; ovf = (r > MAXV); j = 1; end
         11: begin
            if (mA >= mB) r = mA - mB;
            else begin r = mB - mA; ng = 1; end
         end
         12: begin
            r = mA * mB; lat = 1 + mB;
            if (r > MAXV) begin ovf = 1'b1; j = MAXV / mA + 1; end
         end
         default: r = mA;
      endcase
      drive(14);
      chk("exec_status", 32'(status), 2);
      busy = 0;
      while (status === 2'b10 && busy < 20000) begin
         busy++;
         @(posedge clock); #1;
      end
      if (ovf) begin
         chk("ovf_latency", busy, j);
         chk("ovf_status", 32'(status), 0);
         mMode = 3;
      end else begin
         chk("busy_cycles", busy, lat);
         mAcc = r; mNeg = ng; mMode = 2;
         run_show(r, ng);
      end
   endtask

   task automatic press(input int k);
      int n;
      bit isd, iso;
      isd = (k <= 9);
      iso = (k >= 10 && k <= 12);
      if (mMode == 3) begin
         drive(k);
      end else if (k == 13) begin
         drive(k);
         model_clear();
      end else if (mMode == 0 || mMode == 1) begin
         if (k == 14) begin
            if (mMode == 0) mOp = 13;
            do_equals();
         end else begin
            drive(k);
            if (isd) begin
               if (mCnt < DIGITS) begin
                  if (mMode == 0) mA = mA * 10 + k; else mB = mB * 10 + k;
                  mCnt++;
               end
            end else if (k == 15) begin
               if (mMode == 0) mA = mA / 10; else mB = mB / 10;
               if (mCnt > 0) mCnt--;
            end else if (iso) begin
               if (mMode == 0) begin
                  mOp = k; mMode = 1; mB = 0; mCnt = 0;
               end else if (mCnt == 0) begin
                  mOp = k;
               end else begin
                  mMode = 3;
               end
            end
         end
      end else begin
         drive(k);
         if (k == 14) begin
            n = 0;
            while (status !== 2'b11 && n < 4) begin
               n++;
               @(posedge clock); #1;
            end
            run_show(mAcc, mNeg);
         end else if (isd) begin
            mA = k; mCnt = 1; mMode = 0;
         end else if (iso) begin
            if (mNeg != 0) mMode = 3;
            else begin mA = mAcc; mOp = k; mMode = 1; mB = 0; mCnt = 0; end
         end
      end
      chk("key_status", 32'(status), (mMode == 3) ? 0 : 1);
      chk("key_pos", 32'(pos), 0);
      chk("key_dig", 32'(dig), 0);
   endtask

   initial begin
      int nA, nB;
      model_clear();
      repeat (2) @(posedge clock);
      #1;
      chk("init_status", 32'(status), 1);
      chk("init_pos", 32'(pos), 0);
      chk("init_dig", 32'(dig), 0);
      reset = 1'b0;

      // add 12 + 34
      press(1); press(2); press(10); press(3); press(4); press(14);
      chk("add_result", mAcc, 46);
      // negative subtraction 5 - 12, then chaining a negative result errors
      press(5); press(11); press(1); press(2); press(14);
      chk("sub_neg", mNeg, 1);
      press(10);
      do_reset();
      // multiply 25 * 4, then re-show
      press(2); press(5); press(12); press(4); press(14);
      chk("mul_result", mAcc, 100);
      press(14);
      // overflow 9999 * 2; D and E ignored in error
      press(9); press(9); press(9); press(9); press(12); press(2); press(14);
      press(13); press(14);
      do_reset();
      // entry limit, backspace, chaining
      press(1); press(2); press(3); press(4); press(5); press(15);
      chk("entry_a", mA, 123);
      press(10); press(7); press(14);
      chk("sum_130", mAcc, 130);
      press(10); press(1); press(14);
      chk("chain_131", mAcc, 131);

      // reset during the second IMPRIME cycle, with a competing key strobe
      press(1); press(2); press(10); press(3); press(4);
      drive(14);
      chk("rs_exec", 32'(status), 2);
      @(posedge clock); #1;
      chk("rs_pos0", 32'(pos), 0);
      chk("rs_dig0", 32'(dig), 6);
      @(posedge clock); #1;
      chk("rs_pos1", 32'(pos), 1);
      chk("rs_dig1", 32'(dig), 4);
      reset = 1'b1; cmd = 4'd5; cmd_valid = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; cmd_valid = 1'b0;
      model_clear();
      chk("rs_status", 32'(status), 1);
      chk("rs_pos", 32'(pos), 0);
      chk("rs_dig", 32'(dig), 0);
      press(14);
      press(7); press(14);
      chk("rs_entry_a", mAcc, 7);

      // randomized sessions, with stray keys during SHOW
      poke_en = 1'b1;
      for (int t = 0; t < 60; t++) begin
         if (mMode == 3) do_reset();
         if ($urandom_range(0, 9) == 0) press(13);
         nA = $urandom_range(0, 5);
         for (int i = 0; i < nA; i++) press($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) press(15);
         if ($urandom_range(0, 7) == 0) begin
            press(14);
            continue;
         end
         press($urandom_range(10, 12));
         if ($urandom_range(0, 5) == 0) press($urandom_range(10, 12));
         if (mMode != 1) continue;
         nB = (mOp == 12) ? $urandom_range(0, 2) : $urandom_range(0, 5);
         for (int i = 0; i < nB; i++) press($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) press(15);
         if ($urandom_range(0, 11) == 0) press($urandom_range(10, 12));
         if (mMode == 1 && mOp == 12 && mB > 99) press(13);
         press(14);
         if ($urandom_range(0, 4) == 0) press(14);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
